toy_bus_dtcm_responder: RTL

Target-side endpoint of the ToyBus request/ack protocol. It accepts ToyBusReq beats leaving the DTCM arbitration node and performs the access on a single-port 256-bit DTCM SRAM. It returns ToyBusAck beats toward the node's ack decoder. Read data and acks pass through a credit-guarded ack FIFO, so ack backpressure never drops or stalls an SRAM read in flight.

---
 rtl/toy_bus_pkg.sv | 22 ++
 rtl/toy_bus_dtcm_rsp_fifo.sv | 58 +++++
 rtl/toy_bus_dtcm_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/toy_bus_pkg.sv
// ToyBus shared widths, opcodes and the ack payload bundle.
// Used by the DTCM responder and its ack FIFO.
package toy_bus_pkg;

  localparam int TB_ADDR_W = 32;
  localparam int TB_STRB_W = 32;
  localparam int TB_DATA_W = 256;
  localparam int TB_ID_W   = 4;
  localparam int TB_SB_W   = 10;

  localparam logic TB_OPC_RD = 1'b0;
  localparam logic TB_OPC_WR = 1'b1;

  typedef struct packed {
    logic                 opcode;
    logic [TB_DATA_W-1:0] data;
    logic [TB_SB_W-1:0]   sideband;
    logic [TB_ID_W-1:0]   src_id;
    logic [TB_ID_W-1:0]   tgt_id;
  } ack_pay_t;

endpackage

// File: rtl/toy_bus_dtcm_rsp_fifo.sv
// Synchronous ack FIFO for the DTCM responder.
// Head entry is presented combinationally and held until popped.
module toy_bus_dtcm_rsp_fifo
  import toy_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  ack_pay_t din,
  input  logic     pop,
  output ack_pay_t dout,
  output logic     empty,
  output logic     full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  ack_pay_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // explicit wrap keeps non power-of-two depths correct
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: cnt <= cnt + 1'b1;
        do_pop && !do_push: cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/toy_bus_dtcm_responder.sv
// ToyBus target endpoint driving a single-port 256b DTCM SRAM.
// TOY_BUS_RSP_WR_ACK_EN: writes also return acks (else posted).
module toy_bus_dtcm_responder
  import toy_bus_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter int ACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in0_req_vld,
  output logic                 in0_req_rdy,
  input  logic [TB_ADDR_W-1:0] in0_req_addr,
  input  logic [TB_STRB_W-1:0] in0_req_strb,
  input  logic [TB_DATA_W-1:0] in0_req_data,
  input  logic                 in0_req_opcode,
  input  logic [TB_ID_W-1:0]   in0_req_src_id,
  input  logic [TB_ID_W-1:0]   in0_req_tgt_id,
  input  logic [TB_SB_W-1:0]   in0_req_sideband,
  output logic                 in0_ack_vld,
  input  logic                 in0_ack_rdy,
  output logic                 in0_ack_opcode,
  output logic [TB_DATA_W-1:0] in0_ack_data,
  output logic [TB_SB_W-1:0]   in0_ack_sideband,
  output logic [TB_ID_W-1:0]   in0_ack_src_id,
  output logic [TB_ID_W-1:0]   in0_ack_tgt_id,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [TB_STRB_W-1:0] mem_wstrb,
  output logic [TB_DATA_W-1:0] mem_wdata,
  input  logic [TB_DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(ACK_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ACK_DEPTH);

  logic [CW-1:0]      credit_cnt;
  logic               accept;
  logic               ack_gen;
  logic               inc;
  logic               pop;
  logic               s1_vld;
  logic               s1_opc;
  logic [TB_SB_W-1:0] s1_sb;
  logic [TB_ID_W-1:0] s1_src;
  logic [TB_ID_W-1:0] s1_tgt;
  ack_pay_t           push_pay;
  ack_pay_t           head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               unused_addr;

  assign in0_req_rdy = (credit_cnt < DEPTH_C);
  assign accept      = in0_req_vld && in0_req_rdy;

`ifdef TOY_BUS_RSP_WR_ACK_EN
  assign ack_gen = 1'b1;
`else
  assign ack_gen = (in0_req_opcode == TB_OPC_RD);
`endif

  assign inc = accept && ack_gen;

  assign mem_en    = accept;
  assign mem_we    = accept && (in0_req_opcode == TB_OPC_WR);
  assign mem_addr  = in0_req_addr[MEM_AW+4:5];
  assign mem_wstrb = in0_req_strb;
  assign mem_wdata = in0_req_data;

  assign unused_addr = ^{in0_req_addr[TB_ADDR_W-1:MEM_AW+5],
                         in0_req_addr[4:0]};

  // ids swap so the ack routes back to the requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_opc <= TB_OPC_RD;
      s1_sb  <= '0;
      s1_src <= '0;
      s1_tgt <= '0;
    end else begin
      s1_vld <= inc;
      if (inc) begin
        s1_opc <= in0_req_opcode;
        s1_sb  <= in0_req_sideband;
        s1_src <= in0_req_tgt_id;
        s1_tgt <= in0_req_src_id;
      end
    end
  end

  always_comb begin
    push_pay          = '0;
    push_pay.opcode   = s1_opc;
    push_pay.data     = (s1_opc == TB_OPC_RD) ? mem_rdata : '0;
    push_pay.sideband = s1_sb;
    push_pay.src_id   = s1_src;
    push_pay.tgt_id   = s1_tgt;
  end

  toy_bus_dtcm_rsp_fifo #(
    .DEPTH(ACK_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (s1_vld),
    .din  (push_pay),
    .pop  (pop),
    .dout (head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign in0_ack_vld      = !fifo_empty;
  assign pop              = in0_ack_vld && in0_ack_rdy;
  assign in0_ack_opcode   = head.opcode;
  assign in0_ack_data     = head.data;
  assign in0_ack_sideband = head.sideband;
  assign in0_ack_src_id   = head.src_id;
  assign in0_ack_tgt_id   = head.tgt_id;

  // credits span s1 plus the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= '0;
    end else begin
      unique case (1'b1)
        inc && !pop: credit_cnt <= credit_cnt + 1'b1;
        pop && !inc: credit_cnt <= credit_cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && s1_vld) assert (!fifo_full);
  end
`endif

endmodule
